// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its neighbours.
// Contents: instruction/PC widths, reset fetch address, instruction field
// positions for the decode stage, and the fetch FSM state type.
package cpu_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_W    = 64;
   localparam logic [63:0] RESET_PC = 64'h2000;

   // Instruction field positions
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 27;
   localparam int unsigned RD_MSB     = 26;
   localparam int unsigned RD_LSB     = 22;
   localparam int unsigned RS_MSB     = 21;
   localparam int unsigned RS_LSB     = 17;
   localparam int unsigned RT_MSB     = 16;
   localparam int unsigned RT_LSB     = 12;
   localparam int unsigned L_MSB      = 11;
   localparam int unsigned L_LSB      = 0;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HALT
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} entries for the fetch stage.
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   flush       discard all entries (dominates push/pop)
//   push, din   write an entry
//   pop         remove the head entry (ignored when empty)
//   dout        head entry, zero when empty
//   count       number of valid entries (0..DEPTH)
module fetch_fifo #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full queue is accepted only when the head leaves this cycle.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

   assign dout = (count != '0) ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests,
// queues returned words with their PCs and hands them to decode.
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_ready      request channel to instruction memory
//   imem_rvalid/imem_rdata             in-order response channel
//   redirect_valid/redirect_pc         flush and restart at a new PC
//   halt_req                           stop issuing fetches
//   instr_valid/instr/instr_pc/instr_ready  decode handshake
//   halted                             halted with nothing outstanding
module fetch_unit #(
   parameter int unsigned      PC_W     = cpu_pkg::PC_W,
   parameter logic [PC_W-1:0]  RESET_PC = PC_W'(cpu_pkg::RESET_PC),
   parameter int unsigned      DEPTH    = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   output logic                        imem_req,
   output logic [PC_W-1:0]             imem_addr,
   input  logic                        imem_ready,
   input  logic                        imem_rvalid,
   input  logic [cpu_pkg::INSTR_W-1:0] imem_rdata,
   input  logic                        redirect_valid,
   input  logic [PC_W-1:0]             redirect_pc,
   input  logic                        halt_req,
   output logic                        instr_valid,
   output logic [cpu_pkg::INSTR_W-1:0] instr,
   output logic [PC_W-1:0]             instr_pc,
   input  logic                        instr_ready,
   output logic                        halted
);

   import cpu_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned FW = PC_W + INSTR_W;

   fetch_state_t    state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] resp_pc;
   logic [PC_W-1:0] target_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   out_next;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     occupancy;
   logic [FW-1:0]   fifo_dout;
   logic            accept;
   logic            rsp;
   logic            do_redirect;
   logic            push;
   logic            pop;

   assign target_pc   = redirect_pc & ~PC_W'(3);
   assign do_redirect = redirect_valid && (state != IDLE);
   assign accept      = imem_req && imem_ready;
   // Responses with nothing outstanding are protocol errors and are ignored.
   assign rsp         = imem_rvalid && (outstanding != '0);
   assign out_next    = outstanding + CW'(accept) - CW'(rsp);

   // Requests are gated by in-flight plus buffered, so the queue never overflows.
   assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req  = (state == FETCH) && (occupancy < (CW+1)'(DEPTH));
   assign imem_addr = pc;

   assign push = rsp && (drop_cnt == '0) && !do_redirect;
   assign pop  = instr_valid && instr_ready;

   assign instr_valid = (fifo_count != '0);
   assign instr_pc    = fifo_dout[FW-1:INSTR_W];
   assign instr       = fifo_dout[INSTR_W-1:0];
   assign halted      = (state == HALT) && (outstanding == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= out_next;
         if (do_redirect) begin
            // Everything still in flight after this edge belongs to the old path.
            pc       <= target_pc;
            resp_pc  <= target_pc;
            drop_cnt <= out_next;
            state    <= FETCH;
         end else begin
            if (accept) pc <= pc + PC_W'(4);
            if (rsp) begin
               if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
               else                resp_pc  <= resp_pc + PC_W'(4);
            end
            case (state)
               IDLE:    state <= FETCH;
               FETCH:   if (halt_req) state <= HALT;
               HALT:    state <= HALT;
               default: state <= IDLE;
            endcase
         end
      end
   end

   fetch_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (do_redirect),
      .push  (push),
      .din   ({resp_pc, imem_rdata}),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of `control_unit`. It owns the program counter, issues in-order requests to instruction memory, and buffers returned 32-bit words with their PCs in a small queue. It presents one instruction at a time to decode over a valid/ready handshake. It also accepts PC redirects (taken branches) and a halt request from downstream, discarding wrong-path responses that are still in flight.

## Interface
Parameters:
- `PC_W`, 64, program counter / memory address width
- `RESET_PC`, 64'h2000, first fetch address after reset
- `DEPTH`, 4, instruction queue entries; also the max outstanding-plus-buffered count (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted = 0)
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  PC_W  fetch address (always 4-byte aligned)
- `imem_ready`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  response valid; responses return in request order
- `imem_rdata`  in  32  instruction word
- `redirect_valid`  in  1  flush and restart fetching at `redirect_pc`
- `redirect_pc`  in  PC_W  new fetch target (bits [1:0] forced to 0)
- `halt_req`  in  1  stop issuing fetches
- `instr_valid`  out  1  queue head valid
- `instr`  out  32  queue head word; feeds `control_unit.instr`
- `instr_pc`  out  PC_W  address of `instr`
- `instr_ready`  in  1  decode consumes head
- `halted`  out  1  in HALT with nothing outstanding

## Operation
- States: IDLE → FETCH → HALT. IDLE lasts exactly one cycle after reset release, then FETCH.
- FETCH: `imem_req` = 1 when `outstanding + count < DEPTH`; `imem_addr` = `pc`. On `imem_req && imem_ready`: `pc += 4`, `outstanding++`.
- Responses: each `imem_rvalid` decrements `outstanding`. If `drop_cnt > 0`, the word is discarded and `drop_cnt--`. Otherwise {`resp_pc`, `imem_rdata`} is pushed and `resp_pc += 4`.
- Output: head of the queue; pop on `instr_valid && instr_ready`.
- Redirect (any state except IDLE):
  - Queue cleared; `pc` and `resp_pc` ← `redirect_pc`.
  - `drop_cnt` ← `outstanding + accepted_this_cycle − rvalid_this_cycle`.
  - A response arriving in the redirect cycle is discarded. A pop in that cycle is ignored.
  - State ← FETCH. Redirect overrides `halt_req` in the same cycle.
- `halt_req` in FETCH → HALT. HALT: `imem_req` = 0. In-flight responses are still accepted and queued, and the queue still drains. `halted` = (state == HALT && `outstanding` == 0).
- HALT leaves only via redirect or reset.
- `imem_rvalid` with `outstanding` == 0 is a protocol error: ignored, no state change.
- PC arithmetic wraps modulo 2^PC_W.

## Timing
- Reset values: `imem_req` 0, `imem_addr` RESET_PC, `instr_valid` 0, `instr` 0, `instr_pc` 0, `halted` 0. Internal counters 0; `pc` = `resp_pc` = RESET_PC.
- Reset mid-operation: all state is cleared asynchronously. Later responses to pre-reset requests are protocol errors and are ignored.
- First `imem_req` is on the 2nd rising edge after reset release (one edge spent in IDLE).
- Latency: response at edge T makes `instr_valid` high after edge T (registered queue, no bypass).
- Sustained throughput of one instruction per cycle when memory has 1-cycle latency and `instr_ready` = 1.
- No overflow is possible by construction. Full condition: `outstanding + count == DEPTH` blocks requests.
- Push and pop in the same cycle on a full queue are both legal.
- `imem_req`/`imem_addr` are combinational from registered state only, never from `imem_ready`.

## Structure
- `cpu_pkg`:
  - `INSTR_W` = 32, `PC_W` default, `RESET_PC`.
  - Instruction field positions: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], L [11:0].
  - `fetch_state_t` enum {IDLE, FETCH, HALT}.
- Sub-module `fetch_fifo`: synchronous FIFO with parameterised width and depth, plus a `flush` input and `count` output. It holds {pc, instr}. All counters and the FSM live in `fetch_unit`.

## Test plan
- Reset release, `imem_ready` = 1, 1-cycle memory returning 32'h0800_0002 → requests at 0x2000, 0x2004, … on consecutive cycles. First `instr_valid` shows `instr` 32'h0800_0002, `instr_pc` 0x2000.
- Hold `instr_ready` = 0 with DEPTH = 4 → exactly 4 requests issued, then `imem_req` stays 0. Release `instr_ready` → 4 pops in order, then requests resume at 0x2010.
- 2 requests outstanding, then `redirect_valid` with `redirect_pc` 0x3000 → both old responses are dropped. Next `instr_pc` = 0x3000 and `instr` = the word at 0x3000.
- Redirect in the same cycle as an accepted request and an arriving response → `drop_cnt` = outstanding + 1 − 1, and no stale instruction ever reaches `instr_valid`.
- `halt_req` with 2 requests in flight → `imem_req` drops next cycle. `halted` = 1 once both responses return, and both are still delivered. A redirect to 0x2000 then resumes fetching.
- Assert `reset` low mid-stream → all outputs return to reset values immediately. A later `imem_rvalid` with nothing outstanding is ignored.
